// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: exhaustive truth-table stimulus and checker
// for the f/g/h lab blocks. Optional: TTSEQ_FAILMASK_EN adds fail_mask.
module truth_table_sequencer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  sel,
  input  logic        dut_f,
  input  logic        dut_g,
  input  logic        dut_h,
  output logic [3:0]  stim,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [4:0]  err_cnt,
  output logic [3:0]  first_fail_idx
`ifdef TTSEQ_FAILMASK_EN
  ,
  output logic [15:0] fail_mask
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK,
    DONE
  } state_t;

  localparam logic [3:0] LP_CNT_LAST = 4'(SETTLE - 1);

  state_t     r_state;
  logic [3:0] r_idx;
  logic [1:0] r_sel;
  logic [3:0] r_cnt;
  logic [3:0] r_stim;
  logic       r_busy;
  logic       r_done;
  logic       r_fail;
  logic [4:0] r_err;
  logic [3:0] r_first;
`ifdef TTSEQ_FAILMASK_EN
  logic [15:0] r_mask;
`endif

  logic [3:0] w_last_idx;
  logic [3:0] w_next_idx;
  logic [3:0] w_next_stim;
  logic       w_a;
  logic       w_b;
  logic       w_c;
  logic       w_d;
  logic       w_gf;
  logic       w_gg;
  logic       w_gh;
  logic       w_bad;

  // Place index bits onto {a,b,c,d} for the selected target width.
  function automatic logic [3:0] f_map(
    input logic [3:0] idx,
    input logic [1:0] s
  );
    logic [3:0] v;
    v = idx;
    unique case (s)
      2'd0:    v = {idx[1:0], 2'b00};
      2'd1:    v = {idx[2:0], 1'b0};
      default: v = idx;
    endcase
    return v;
  endfunction

  // Golden model, vector bounds and the per-vector verdict.
  always_comb begin
    w_a = r_stim[3];
    w_b = r_stim[2];
    w_c = r_stim[1];
    w_d = r_stim[0];
    w_gf = w_a ^ w_b;
    w_gg = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);
    w_gh = w_d | (w_c & ~(w_a & w_b));
    w_last_idx = 4'd15;
    w_bad = 1'b0;
    unique case (r_sel)
      2'd0: begin
        w_last_idx = 4'd3;
        w_bad = dut_f != w_gf;
      end
      2'd1: begin
        w_last_idx = 4'd7;
        w_bad = dut_g != w_gg;
      end
      2'd2: begin
        w_bad = dut_h != w_gh;
      end
      default: begin
        w_bad = (dut_f != w_gf) | (dut_g != w_gg)
              | (dut_h != w_gh);
      end
    endcase
    w_next_idx = r_idx + 4'd1;
    w_next_stim = f_map(w_next_idx, r_sel);
  end

  // Sequencer FSM with registered outputs and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_stim  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fail  <= 1'b0;
      r_err   <= '0;
      r_first <= '0;
`ifdef TTSEQ_FAILMASK_EN
      r_mask  <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= DRIVE;
            r_idx   <= '0;
            r_sel   <= sel;
            r_cnt   <= '0;
            r_stim  <= '0;
            r_busy  <= 1'b1;
            r_fail  <= 1'b0;
            r_err   <= '0;
            r_first <= '0;
`ifdef TTSEQ_FAILMASK_EN
            r_mask  <= '0;
`endif
          end
        end
        DRIVE: begin
          if (r_cnt == LP_CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= CHECK;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        CHECK: begin
          if (w_bad) begin
            r_err <= r_err + 5'd1;
            if (!r_fail) begin
              r_fail  <= 1'b1;
              r_first <= r_idx;
            end
`ifdef TTSEQ_FAILMASK_EN
            r_mask[r_idx] <= 1'b1;
`endif
          end
          if (r_idx == w_last_idx) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_idx   <= w_next_idx;
            r_stim  <= w_next_stim;
            r_state <= DRIVE;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign stim           = r_stim;
  assign busy           = r_busy;
  assign done           = r_done;
  assign fail           = r_fail;
  assign err_cnt        = r_err;
  assign first_fail_idx = r_first;
`ifdef TTSEQ_FAILMASK_EN
  assign fail_mask      = r_mask;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: vector table of runs plus hand-written
// sequences for start hold, start during run and mid-run reset.
module tb_truth_table_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start1;
  logic       start3;
  logic [1:0] sel;
  logic       f1, g1, h1;
  logic       f3, g3, h3;
  logic [3:0] stim1, stim3;
  logic       busy1, busy3;
  logic       done1, done3;
  logic       fail1, fail3;
  logic [4:0] err1, err3;
  logic [3:0] first1, first3;
`ifdef TTSEQ_FAILMASK_EN
  logic [15:0] mask1, mask3;
`endif
  int fmode;
  int checks;
  int failures;

  truth_table_sequencer #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sel(sel),
    .dut_f(f1), .dut_g(g1), .dut_h(h1), .stim(stim1),
    .busy(busy1), .done(done1), .fail(fail1),
    .err_cnt(err1), .first_fail_idx(first1)
`ifdef TTSEQ_FAILMASK_EN
    , .fail_mask(mask1)
`endif
  );

  truth_table_sequencer #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .sel(sel),
    .dut_f(f3), .dut_g(g3), .dut_h(h3), .stim(stim3),
    .busy(busy3), .done(done3), .fail(fail3),
    .err_cnt(err3), .first_fail_idx(first3)
`ifdef TTSEQ_FAILMASK_EN
    , .fail_mask(mask3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lab blocks: 0 good, 1 f stuck 0, 2 g=a&b, 3 h stuck 1, 4 all inverted
  function automatic logic [2:0] lab(input logic [3:0] s, input int m);
    logic a, b, c, d, f, g, h;
    a = s[3]; b = s[2]; c = s[1]; d = s[0];
    f = a ^ b;
    g = (a & b) | (a & c) | (b & c);
    h = d | (c & ~(a & b));
    if (m == 1) f = 1'b0;
    if (m == 2) g = a & b;
    if (m == 3) h = 1'b1;
    if (m == 4) begin f = ~f; g = ~g; h = ~h; end
    return {f, g, h};
  endfunction

  assign {f1, g1, h1} = lab(stim1, fmode);
  assign {f3, g3, h3} = lab(stim3, fmode);

  function automatic logic [3:0] mapv(input int k, input logic [1:0] s);
    logic [3:0] kk;
    kk = 4'(k);
    case (s)
      2'd0:    return {kk[1:0], 2'b00};
      2'd1:    return {kk[2:0], 1'b0};
      default: return kk;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  typedef struct {
    bit         u3;
    logic [1:0] sel;
    int         fm;
    bit         disturb;
    int         err;
    int         first;
    int         fail;
    int         mask;
  } vec_t;

  // Start one run and follow it edge by edge up to and past done.
  task automatic run(input bit u3, input logic [1:0] s_sel,
                     input bit disturb, output int de,
                     output bit sok, output bit bok);
    int n, per, e;
    n = (s_sel == 2'd0) ? 4 : (s_sel == 2'd1) ? 8 : 16;
    per = u3 ? 4 : 2;
    sok = 1'b1; bok = 1'b1; de = -1; e = 0;
    @(negedge clk);
    if (busy1 !== 1'b0 || busy3 !== 1'b0) bok = 1'b0;
    sel = s_sel;
    if (u3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start3 = 1'b0;
    while (de < 0 && e < 400) begin
      if (e < n * per) begin
        if ((u3 ? stim3 : stim1) !== mapv(e / per, s_sel)) sok = 1'b0;
      end else begin
        if ((u3 ? stim3 : stim1) !== mapv(n - 1, s_sel)) sok = 1'b0;
      end
      if ((u3 ? busy3 : busy1) !== 1'b1) bok = 1'b0;
      if ((u3 ? done3 : done1) === 1'b1) de = e;
      if (disturb && e == 5) begin
        sel = ~s_sel;
        if (u3) start3 = 1'b1; else start1 = 1'b1;
      end
      if (disturb && e == 7) begin
        start1 = 1'b0; start3 = 1'b0;
      end
      if (de < 0) begin
        @(posedge clk); #1;
        e++;
      end
    end
    repeat (6) begin
      @(posedge clk); #1;
      if ((u3 ? busy3 : busy1) !== 1'b0) bok = 1'b0;
      if ((u3 ? done3 : done1) !== 1'b0) bok = 1'b0;
      if ((u3 ? stim3 : stim1) !== mapv(n - 1, s_sel)) sok = 1'b0;
    end
  endtask

  vec_t tbl[12];

  initial begin
    int de, e, nd;
    bit sok, bok;
    checks = 0; failures = 0;
    fmode = 0; sel = 2'd0;
    start1 = 1'b0; start3 = 1'b0;
    rst_n = 1'b0;

    tbl[0]  = '{0, 2'd2, 0, 0, 0, 0, 0, 16'h0000};
    tbl[1]  = '{0, 2'd0, 1, 0, 2, 1, 1, 16'h0006};
    tbl[2]  = '{0, 2'd3, 2, 0, 4, 6, 1, 16'h0CC0};
    tbl[3]  = '{0, 2'd0, 0, 1, 0, 0, 0, 16'h0000};
    tbl[4]  = '{0, 2'd1, 2, 0, 2, 3, 1, 16'h0028};
    tbl[5]  = '{0, 2'd2, 1, 0, 0, 0, 0, 16'h0000};
    tbl[6]  = '{0, 2'd1, 1, 1, 0, 0, 0, 16'h0000};
    tbl[7]  = '{0, 2'd3, 1, 0, 8, 4, 1, 16'h0FF0};
    tbl[8]  = '{0, 2'd2, 3, 0, 5, 0, 1, 16'h5111};
    tbl[9]  = '{0, 2'd3, 4, 0, 16, 0, 1, 16'hFFFF};
    tbl[10] = '{1, 2'd1, 0, 0, 0, 0, 0, 16'h0000};
    tbl[11] = '{1, 2'd0, 1, 1, 2, 1, 1, 16'h0006};

    #12;
    chk("rst_stim", int'(stim1), 0);
    chk("rst_busy_done", int'({busy1, done1}), 0);
    chk("rst_results", int'({fail1, err1, first1}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 12; t++) begin
      int n, per;
      fmode = tbl[t].fm;
      n = (tbl[t].sel == 2'd0) ? 4 : (tbl[t].sel == 2'd1) ? 8 : 16;
      per = tbl[t].u3 ? 4 : 2;
      run(tbl[t].u3, tbl[t].sel, tbl[t].disturb, de, sok, bok);
      chk($sformatf("row%0d_done_edge", t), de, n * per);
      chk($sformatf("row%0d_stim_seq", t), int'(sok), 1);
      chk($sformatf("row%0d_busy_done", t), int'(bok), 1);
      chk($sformatf("row%0d_err_cnt", t),
          int'(tbl[t].u3 ? err3 : err1), tbl[t].err);
      chk($sformatf("row%0d_first_idx", t),
          int'(tbl[t].u3 ? first3 : first1), tbl[t].first);
      chk($sformatf("row%0d_fail", t),
          int'(tbl[t].u3 ? fail3 : fail1), tbl[t].fail);
`ifdef TTSEQ_FAILMASK_EN
      chk($sformatf("row%0d_mask", t),
          int'(tbl[t].u3 ? mask3 : mask1), tbl[t].mask);
`endif
    end

    // start held high: back-to-back runs, results cleared at restart
    fmode = 1;
    @(negedge clk);
    sel = 2'd0; start1 = 1'b1;
    @(posedge clk); #1;
    e = 0; de = -1;
    while (de < 0 && e < 100) begin
      if (done1 === 1'b1) de = e;
      else begin @(posedge clk); #1; e++; end
    end
    chk("hold_done_edge", de, 8);
    chk("hold_err_first_run", int'(err1), 2);
    @(posedge clk); #1;
    chk("hold_idle_gap", int'({busy1, done1}), 0);
    @(posedge clk); #1;
    chk("hold_restart_busy", int'(busy1), 1);
    chk("hold_restart_clear", int'({fail1, err1, first1}), 0);
    start1 = 1'b0;
    e = 0; nd = 0;
    while (e < 30) begin
      @(posedge clk); #1; e++;
      if (done1 === 1'b1) nd++;
    end
    chk("hold_second_done_count", nd, 1);
    chk("hold_second_err", int'(err1), 2);

    // reset at edge 10 of a sel=2 run with h stuck high
    fmode = 3;
    @(negedge clk);
    sel = 2'd2; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("pre_reset_err", int'(err1), 2);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stim", int'(stim1), 0);
    chk("rst_mid_busy_done", int'({busy1, done1}), 0);
    chk("rst_mid_results", int'({fail1, err1, first1}), 0);
`ifdef TTSEQ_FAILMASK_EN
    chk("rst_mid_mask", int'(mask1), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) nd++;
    end
    chk("rst_no_done", nd, 0);
    fmode = 0;
    run(1'b0, 2'd2, 1'b0, de, sok, bok);
    chk("post_rst_done_edge", de, 32);
    chk("post_rst_stim_seq", int'(sok), 1);
    chk("post_rst_err", int'({fail1, err1}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

Self-checking exhaustive stimulus controller for the lab's combinational function blocks: XOR (f), 3-input majority (g) and the 4-input gate network (h). It sequences every input combination onto the shared a/b/c/d stimulus bus, waits a programmable settle time, and compares each DUT output against an internal golden model. It replaces hand-written `#1` truth-table benches with a synthesizable, clocked checker that can also run on the board.

## Interface
- SETTLE, 1: cycles each vector is held before sampling; legal range 1..15.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request; sampled only in IDLE.
- sel  in  2  target: 0 = f (2 inputs), 1 = g (3 inputs), 2 = h (4 inputs), 3 = all three (4 inputs).
- dut_f, dut_g, dut_h  in  1 each  DUT outputs under test.
- stim  out  4  {a,b,c,d} driven to the DUTs.
- busy  out  1  high from the start edge until DONE is left.
- done  out  1  one-cycle completion pulse.
- fail  out  1  sticky: at least one vector mismatched in this run.
- err_cnt  out  5  number of failing vectors, 0..16.
- first_fail_idx  out  4  vector index of the first mismatch; 0 when fail=0.

## Operation
- Golden model: f = a^b; g = ab | ac | bc; h = d | (c & ~(a&b)).
- Vector count N: sel 0 gives 4, sel 1 gives 8, sel 2 or 3 gives 16. The index i counts 0..N-1.
- Stim mapping:
  - sel 0: a=i[1], b=i[0], c=d=0.
  - sel 1: a=i[2], b=i[1], c=i[0], d=0.
  - sel 2 or 3: {a,b,c,d}=i[3:0].
- sel is latched at the start edge; later changes are ignored until the next run.
- FSM states:
  - IDLE: busy=0. When start=1, clear fail, err_cnt and first_fail_idx, set i=0, latch sel, go to DRIVE.
  - DRIVE: hold stim for SETTLE cycles using the settle counter, then go to CHECK.
  - CHECK: one cycle. At its closing edge, compare the selected DUT output(s) with golden.
    - A vector fails if any compared output mismatches. sel 3 compares f, g and h; a vector counts at most once.
    - On failure: err_cnt+1. If fail was 0, set fail=1 and first_fail_idx=i.
    - If i=N-1, go to DONE; otherwise i+1 and go to DRIVE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start while busy=1 is ignored. If start is held high, a new run begins on the IDLE cycle after DONE.
- Results (fail, err_cnt, first_fail_idx) hold stable from DONE until the next accepted start.
- stim holds its last vector in IDLE and DONE.

## Timing
- Reset (asynchronous, immediate): state=IDLE, i=0, stim=0, busy=0, done=0, fail=0, err_cnt=0, first_fail_idx=0. Mask cleared if compiled in.
- Reset mid-run aborts with no done pulse.
- Let edge 0 be the edge where start is accepted.
  - stim = vector 0 from edge 0.
  - Vector k is driven during edges k·(SETTLE+1) .. k·(SETTLE+1)+SETTLE.
  - Vector k is sampled at edge (k+1)·(SETTLE+1).
- done is high for the single cycle after edge N·(SETTLE+1). busy falls at edge N·(SETTLE+1)+1.
- Result registers update at CHECK edges, so they are final when done rises.
- With SETTLE=1: sel 0 runs 8 cycles plus DONE; sel 2 runs 32 cycles plus DONE.

## Configuration
- TTSEQ_FAILMASK_EN defined:
  - Adds output fail_mask (16 bits). Bit i is set at the CHECK edge of failing vector i.
  - The mask is cleared on an accepted start and on reset.
- TTSEQ_FAILMASK_EN undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
- Correct DUTs, sel=2, SETTLE=1, start pulse -> stim steps 0..15, every vector held 2 cycles. done after edge 32; fail=0, err_cnt=0.
- dut_f tied 0, sel=0 -> vectors 1 and 2 fail. err_cnt=2, first_fail_idx=1, fail=1; fail_mask=0x0006 if enabled.
- dut_g replaced by a&b, others correct, sel=3 -> failing indices 6, 7, 10, 11. err_cnt=4, first_fail_idx=6.
- start pulsed again during a run -> ignored, single done. start held high -> second run begins the cycle after DONE, with results cleared at that edge.
- rst_n low at edge 10 of a sel=2 run -> all outputs 0 immediately. No done. A fresh start afterwards runs normally.
- SETTLE=3, sel=1, correct DUTs -> each vector held 4 cycles. done after edge 32; err_cnt=0.
